dac_xfade_writer: RTL and testbench
===================================

DAC_XFADE_WRITER -- requirements
Module: dac_xfade_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning packed stereo sample width: left in [31:16], right in [15:0], both signed.
REQ-002 SHALL have parameter RAMP_STEP, default 4, meaning gain increment/decrement per accepted sample (full scale 256).
REQ-003 SHALL have parameter MODE_W, default 8, meaning width of mode codes.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port sample_in, input, DATA_WIDTH, the output of the channel-select mux.
REQ-007 SHALL have port sample_valid, input, 1, a one-cycle strobe marking a new sample_in.
REQ-008 SHALL have port mode_req, input, MODE_W, the mode requested by the command FSM (check_ok).
REQ-009 SHALL have port mode_cur, output, MODE_W, the mode applied; the top-level mux SHALL select on this port.
REQ-010 SHALL have port dacfifo_full, input, 1, the DAC FIFO full flag.
REQ-011 SHALL have port dacfifo_wren, output, 1, the DAC FIFO write strobe.
REQ-012 SHALL have port dacfifo_wrdata, output, DATA_WIDTH, the scaled sample written to the FIFO.
REQ-013 SHALL have port busy, output, 1, high while a crossfade is in progress.

Function
REQ-014 SHALL implement the FSM states PASS, FADE_OUT, SWITCH and FADE_IN.
REQ-015 In PASS with gain=256, SHALL go to FADE_OUT when mode_req != mode_cur.
REQ-016 In FADE_OUT, SHALL decrement gain by RAMP_STEP per accepted sample, saturating at 0, and go to SWITCH when gain reaches 0.
REQ-017 In SWITCH, for exactly one cycle, SHALL load mode_cur <= mode_req (sampled in that cycle) and go to FADE_IN.
REQ-018 In FADE_IN, SHALL increment gain by RAMP_STEP per accepted sample, saturating at 256, and go to PASS when gain reaches 256.
REQ-019 If mode_req changes during FADE_IN, SHALL go directly to FADE_OUT from the current gain (no jump).
REQ-020 If mode_req changes during FADE_OUT, SHALL continue the fade; the latest mode_req is taken in SWITCH.
REQ-021 If mode_req returns to mode_cur during FADE_OUT, SHALL still complete FADE_OUT, SWITCH and FADE_IN.
REQ-022 SHALL scale each channel as (ch * gain) >>> 8, using a signed 16x9-bit product and arithmetic shift; gain=256 SHALL give an exact passthrough and gain=0 SHALL give 0.
REQ-023 SHALL register the output: dacfifo_wren pulses exactly 1 cycle after a sample_valid for which dacfifo_full=0, with dacfifo_wrdata valid in that same cycle.
REQ-024 If sample_valid arrives while dacfifo_full=1, SHALL drop the sample, leave gain unchanged and assert no write.
REQ-025 SHALL never assert dacfifo_wren on two consecutive cycles unless sample_valid was asserted on two consecutive cycles.
REQ-026 SHALL drive busy high in FADE_OUT, SWITCH and FADE_IN.

Reset
REQ-027 On reset, SHALL set: state=PASS, gain=256, mode_cur=0 (EN_INITIAL), dacfifo_wren=0, dacfifo_wrdata=0, busy=0.
REQ-028 A reset asserted mid-fade SHALL abort the fade and restore the REQ-027 values on the next edge; a pending write is not issued.

Configuration
REQ-029 With macro DAC_XFADE_DROPCNT_EN defined, SHALL add output drop_cnt (16 bits): count of samples dropped per REQ-024, saturating at 0xFFFF, cleared by reset.
REQ-030 Without DAC_XFADE_DROPCNT_EN, the drop_cnt port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 SHALL take the mode codes (EN_INITIAL..EN_ECHO_2), GAIN_FULL=256 and the FSM state encoding from the shared package audio_pkg.
REQ-032 SHALL use one sub-module, xfade_gain_mul: a combinational signed 16x9 multiply with >>>8, instantiated once per channel.

Verification
REQ-033 Reset, then stream samples 0x4000_C000 with mode_req=0: each sample SHALL be written unchanged, 1 cycle after its valid.
REQ-034 Change mode_req 0->1 with RAMP_STEP=4 and valid every 1000 cycles: 64 samples SHALL ramp out, mode_cur SHALL become 1, 64 samples SHALL ramp in, and busy SHALL be high throughout; the left channel of 0x4000 at gain 128 SHALL give 0x2000.
REQ-035 During FADE_IN at gain 100, change mode_req 1->2: gain SHALL descend from 100 without a jump, and mode_cur SHALL end at 2.
REQ-036 Hold dacfifo_full=1 for 3 valid samples: no wren SHALL occur, gain SHALL stay fixed, and drop_cnt=3 (with DAC_XFADE_DROPCNT_EN defined).
REQ-037 Assert reset at FADE_OUT gain 40: the next cycle SHALL show gain=256, mode_cur=0, busy=0 and wren=0.
REQ-038 Full-scale input 0x8000_7FFF at gain 256 SHALL pass exact; at gain 0 SHALL give 0x0000_0000.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: mode codes, gain constants, crossfade FSM encoding and the
// saturating gain-ramp helpers shared by the DAC crossfade writer.
package audio_pkg;

    // Mode codes as issued by the command FSM
    localparam int         MODE_CODE_W = 8;
    localparam logic [7:0] EN_INITIAL  = 8'd0;
    localparam logic [7:0] EN_NORMAL   = 8'd1;
    localparam logic [7:0] EN_ECHO_1   = 8'd2;
    localparam logic [7:0] EN_ECHO_2   = 8'd3;

    // Gain is unsigned 0..256, so it needs 9 bits; 256 is unity
    localparam int                GAIN_W    = 9;
    localparam logic [GAIN_W-1:0] GAIN_FULL = 9'd256;

    // Crossfade FSM encoding
    typedef enum logic [1:0] {
        XF_PASS     = 2'd0,
        XF_FADE_OUT = 2'd1,
        XF_SWITCH   = 2'd2,
        XF_FADE_IN  = 2'd3
    } xfade_state_t;

    // Step the gain down, clamping at zero
    function automatic logic [GAIN_W-1:0] gain_ramp_down(
        input logic [GAIN_W-1:0] g,
        input logic [GAIN_W-1:0] step
    );
        return (g > step) ? (g - step) : '0;
    endfunction

    // Step the gain up, clamping at unity
    function automatic logic [GAIN_W-1:0] gain_ramp_up(
        input logic [GAIN_W-1:0] g,
        input logic [GAIN_W-1:0] step
    );
        logic [GAIN_W:0] sum;
        sum = {1'b0, g} + {1'b0, step};
        return (sum >= {1'b0, GAIN_FULL}) ? GAIN_FULL : sum[GAIN_W-1:0];
    endfunction

endpackage

// File: rtl/xfade_gain_mul.sv
// xfade_gain_mul: combinational scaling of one signed audio channel by an
// unsigned 0..256 gain, computed as (ch * gain) >>> 8.
module xfade_gain_mul
    import audio_pkg::*;
#(
    parameter int CH_W = 16
) (
    input  logic signed [CH_W-1:0]   ch,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [CH_W-1:0]   scaled
);

    // The gain is zero-extended before the signed multiply so 256 stays positive
    localparam int PW = CH_W + GAIN_W + 1;

    logic signed [PW-1:0] ch_x;
    logic signed [PW-1:0] gain_x;
    logic signed [PW-1:0] product;
    logic                 unused_bits;

    // Signed product, then keep bits [CH_W+7:8] which equals an arithmetic shift by 8
    always_comb begin
        ch_x    = $signed({{(PW-CH_W){ch[CH_W-1]}}, ch});
        gain_x  = $signed({{(PW-GAIN_W){1'b0}}, gain});
        product = ch_x * gain_x;
        scaled  = product[CH_W+7:8];
    end

    // With gain <= 256 the result always fits CH_W bits; the rest are don't-care
    assign unused_bits = ^{product[PW-1:CH_W+8], product[7:0]};

endmodule

// File: rtl/dac_xfade_writer.sv
// dac_xfade_writer: writes channel-mux samples into the DAC FIFO and hides
// mode switches behind a fade-out / switch / fade-in gain ramp.
// Optional build macro DAC_XFADE_DROPCNT_EN adds a 16-bit saturating
// drop_cnt output counting samples lost to a full FIFO.
//
// Handshake: a sample is accepted when sample_valid=1 and dacfifo_full=0 in
// the same cycle; the scaled word appears on dacfifo_wrdata with a one-cycle
// dacfifo_wren pulse on the following cycle. A sample offered while full is
// dropped and does not advance the gain ramp.
module dac_xfade_writer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAMP_STEP  = 4,
    parameter int MODE_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [MODE_W-1:0]     mode_req,
    output logic [MODE_W-1:0]     mode_cur,
    input  logic                  dacfifo_full,
    output logic                  dacfifo_wren,
    output logic [DATA_WIDTH-1:0] dacfifo_wrdata,
    output logic                  busy
`ifdef DAC_XFADE_DROPCNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int                CH_W = DATA_WIDTH / 2;
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    xfade_state_t      state, state_nxt;
    logic [GAIN_W-1:0] gain, gain_nxt;
    logic              accept;
    logic              mode_diff;
    logic [CH_W-1:0]   scaled_l, scaled_r;

    assign accept    = sample_valid & ~dacfifo_full;
    assign mode_diff = (mode_req != mode_cur);
    assign busy      = (state != XF_PASS);

    // FSM and gain register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= XF_PASS;
            gain  <= GAIN_FULL;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    // Next state and next gain; the gain only moves on an accepted sample
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        case (state)
            XF_PASS: begin
                gain_nxt = GAIN_FULL;
                if (mode_diff) state_nxt = XF_FADE_OUT;
            end
            XF_FADE_OUT: begin
                // mode_req is ignored here; the latest value is taken in SWITCH
                if (accept) gain_nxt = gain_ramp_down(gain, STEP);
                if (gain_nxt == '0) state_nxt = XF_SWITCH;
            end
            XF_SWITCH: begin
                state_nxt = XF_FADE_IN;
            end
            XF_FADE_IN: begin
                if (mode_diff) begin
                    // Reverse from the current gain rather than restarting
                    state_nxt = XF_FADE_OUT;
                    if (accept) gain_nxt = gain_ramp_down(gain, STEP);
                    if (gain_nxt == '0) state_nxt = XF_SWITCH;
                end else begin
                    if (accept) gain_nxt = gain_ramp_up(gain, STEP);
                    if (gain_nxt == GAIN_FULL) state_nxt = XF_PASS;
                end
            end
            default: begin
                state_nxt = XF_PASS;
                gain_nxt  = GAIN_FULL;
            end
        endcase
    end

    // Each accepted sample is scaled by the gain it leaves the ramp with
    xfade_gain_mul #(.CH_W(CH_W)) u_mul_l (
        .ch     (sample_in[DATA_WIDTH-1:CH_W]),
        .gain   (gain_nxt),
        .scaled (scaled_l)
    );

    xfade_gain_mul #(.CH_W(CH_W)) u_mul_r (
        .ch     (sample_in[CH_W-1:0]),
        .gain   (gain_nxt),
        .scaled (scaled_r)
    );

    // Applied mode and registered FIFO write port
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_cur       <= MODE_W'(EN_INITIAL);
            dacfifo_wren   <= 1'b0;
            dacfifo_wrdata <= '0;
        end else begin
            if (state == XF_SWITCH) mode_cur <= mode_req;
            dacfifo_wren <= accept;
            if (accept) dacfifo_wrdata <= {scaled_l, scaled_r};
        end
    end

`ifdef DAC_XFADE_DROPCNT_EN
    // Saturating count of samples dropped because the FIFO was full
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (sample_valid && dacfifo_full && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_xfade_writer.sv
// tb_dac_xfade_writer: directed bench for dac_xfade_writer with default
// parameters (32-bit samples, RAMP_STEP=4, MODE_W=8).
module tb_dac_xfade_writer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic [7:0]  mode_req;
    logic [7:0]  mode_cur;
    logic        dacfifo_full;
    logic        dacfifo_wren;
    logic [31:0] dacfifo_wrdata;
    logic        busy;
`ifdef DAC_XFADE_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    dac_xfade_writer dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .mode_req       (mode_req),
        .mode_cur       (mode_cur),
        .dacfifo_full   (dacfifo_full),
        .dacfifo_wren   (dacfifo_wren),
        .dacfifo_wrdata (dacfifo_wrdata),
        .busy           (busy)
`ifdef DAC_XFADE_DROPCNT_EN
        ,
        .drop_cnt       (drop_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    localparam logic [31:0] SMP  = 32'h4000_C000;
    localparam logic [31:0] FULL = 32'h8000_7FFF;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected output for SMP (+0x4000 / -0x4000) at gain g: +/- g*64 exactly
    function automatic logic [31:0] fade_word(input int g);
        logic [15:0] l;
        logic [15:0] r;
        l = 16'(g * 64);
        r = 16'(-(g * 64));
        return {l, r};
    endfunction

    // ---------------- driver tasks ----------------
    // Offer one sample, check the write one cycle later, then check the idle cycle after it
    task automatic send(input logic [31:0] data, input logic exp_wr,
                        input logic [31:0] exp_data, input string tag);
        @(negedge clk);
        sample_in    = data;
        sample_valid = 1'b1;
        if (exp_wr) exp_q.push_back(exp_data);
        @(negedge clk);
        sample_valid = 1'b0;
        check_val({tag, "_wren"}, 32'(dacfifo_wren), 32'(exp_wr));
        if (dacfifo_wren && exp_q.size() > 0)
            check_val({tag, "_data"}, dacfifo_wrdata, exp_q.pop_front());
        @(negedge clk);
        check_val({tag, "_idle"}, 32'(dacfifo_wren), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        mode_req     = 8'd0;
        dacfifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_wren", 32'(dacfifo_wren), 32'd0);
        check_val("rst_data", dacfifo_wrdata, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_mode", 32'(mode_cur), 32'd0);
        reset = 1'b0;

        // Passthrough in PASS, including full-scale extremes
        for (int i = 0; i < 3; i++) send(SMP, 1'b1, SMP, "pass");
        send(FULL, 1'b1, FULL, "pass_fs");
        check_val("pass_busy", 32'(busy), 32'd0);

        // Mode 0 -> 1: 64 samples out, switch, 64 samples in
        mode_req = 8'd1;
        @(negedge clk);
        check_val("fo1_busy0", 32'(busy), 32'd1);
        check_val("fo1_mode0", 32'(mode_cur), 32'd0);
        for (int k = 1; k <= 63; k++) begin
            send(SMP, 1'b1, fade_word(256 - 4 * k), "fo1");
            check_val("fo1_busy", 32'(busy), 32'd1);
            if (k == 32) check_val("fo1_half", dacfifo_wrdata, 32'h2000_E000);
        end
        send(FULL, 1'b1, 32'h0000_0000, "fo1_fs0");
        check_val("sw1_mode", 32'(mode_cur), 32'd1);
        check_val("sw1_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 64; k++) begin
            send(SMP, 1'b1, fade_word(4 * k), "fi1");
            check_val("fi1_busy", 32'(busy), (k < 64) ? 32'd1 : 32'd0);
        end
        send(FULL, 1'b1, FULL, "pass1_fs");

        // Mode 1 -> 2, but request falls back to 1 mid fade-out: full cycle still runs
        mode_req = 8'd2;
        for (int k = 1; k <= 4; k++) send(SMP, 1'b1, fade_word(256 - 4 * k), "fo2");
        mode_req = 8'd1;
        for (int k = 5; k <= 64; k++) send(SMP, 1'b1, fade_word(256 - 4 * k), "fo2b");
        check_val("sw2_mode", 32'(mode_cur), 32'd1);
        check_val("sw2_busy", 32'(busy), 32'd1);

        // Fade in to gain 100, then request mode 2: ramp reverses from 100
        for (int k = 1; k <= 25; k++) send(SMP, 1'b1, fade_word(4 * k), "fi2");
        check_val("fi2_at100", dacfifo_wrdata, 32'h1900_E700);
        mode_req = 8'd2;
        for (int k = 1; k <= 25; k++) send(SMP, 1'b1, fade_word(100 - 4 * k), "rev");
        check_val("rev_mode", 32'(mode_cur), 32'd2);

        // Fade in with three samples dropped on a full FIFO at gain 40
        for (int k = 1; k <= 10; k++) send(SMP, 1'b1, fade_word(4 * k), "fi3");
        dacfifo_full = 1'b1;
        for (int i = 0; i < 3; i++) send(SMP, 1'b0, 32'd0, "drop");
        check_val("drop_hold", dacfifo_wrdata, fade_word(40));
        dacfifo_full = 1'b0;
`ifdef DAC_XFADE_DROPCNT_EN
        check_val("drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        for (int k = 11; k <= 64; k++) send(SMP, 1'b1, fade_word(4 * k), "fi3b");
        check_val("fi3_busy", 32'(busy), 32'd0);
        check_val("fi3_mode", 32'(mode_cur), 32'd2);

        // Reset at fade-out gain 40 with a sample offered in the same cycle
        mode_req = 8'd3;
        for (int k = 1; k <= 54; k++) send(SMP, 1'b1, fade_word(256 - 4 * k), "fo4");
        check_val("fo4_at40", dacfifo_wrdata, 32'h0A00_F600);
        @(negedge clk);
        reset        = 1'b1;
        mode_req     = 8'd0;
        sample_in    = SMP;
        sample_valid = 1'b1;
        @(negedge clk);
        check_val("mrst_wren", 32'(dacfifo_wren), 32'd0);
        check_val("mrst_data", dacfifo_wrdata, 32'd0);
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_mode", 32'(mode_cur), 32'd0);
`ifdef DAC_XFADE_DROPCNT_EN
        check_val("mrst_drop", 32'(drop_cnt), 32'd0);
`endif
        reset        = 1'b0;
        sample_valid = 1'b0;
        send(SMP, 1'b1, SMP, "post_rst");
        check_val("post_rst_busy", 32'(busy), 32'd0);

        // ---------------- final report ----------------
        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
